// File: rtl/slink_prbs9_checker.sv
// slink_prbs9_checker: receive-side PRBS9 checker for S-Link lane bring-up and BER test.
// It seeds its predictor from two received bytes, then verifies LOCK_CNT correct bytes
// before locking. While locked it flags and counts errored bytes. It drops lock when
// ERR_THRESH errored bytes land inside one WINDOW-byte window.
// Optional build macro SLINK_PRBS9_CHK_BITCNT_EN: err_count advances by the number of
// flipped bits per errored byte instead of by one.
module slink_prbs9_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 8,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             locked,
    output logic             err,
    output logic             lock_lost,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {
        IDLE,
        SEED_A,
        SEED_B,
        VERIFY,
        LOCKED
    } state_t;

    localparam logic [7:0]  LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
    localparam logic [15:0] THRESH   = 16'(ERR_THRESH);

    state_t      state, state_next;
    logic        b0_lsb, b0_lsb_next;
    logic [8:0]  exp_q, exp_next;
    logic [7:0]  good_cnt, good_next;
    logic [15:0] win_cnt, win_next;
    logic [15:0] errb_cnt, errb_next;
    logic [15:0] errb_base;
    logic        win_wrap;
    logic        locked_next, err_next, lost_next, cnt_inc_en;
    logic [3:0]  cnt_inc;
    logic [8:0]  exp_adv;
    logic [7:0]  diff;
    logic        mismatch;
    logic [8:0]  seed;
    logic [ERR_W+3:0] cnt_sum;
    logic [ERR_W-1:0] cnt_sat;

    // Advance the PRBS9 state by eight bit-times; the low byte is the expected data.
    function automatic logic [8:0] prbs9_adv(input logic [8:0] p);
        return {p[0],
                p[8] ^ p[4],
                p[7] ^ p[3],
                p[6] ^ p[2],
                p[5] ^ p[1],
                p[4] ^ p[0],
                p[3] ^ p[8] ^ p[4],
                p[2] ^ p[7] ^ p[3],
                p[1] ^ p[6] ^ p[2]};
    endfunction

    // Only bit 0 of the first seeding byte matters, so only that bit is kept.
    assign exp_adv  = prbs9_adv(exp_q);
    assign diff     = rx_data ^ exp_adv[7:0];
    assign mismatch = |diff;
    assign seed     = {b0_lsb, rx_data};

`ifdef SLINK_PRBS9_CHK_BITCNT_EN
    // Count the flipped bits of the received byte against the prediction.
    always_comb begin
        cnt_inc = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_inc = cnt_inc + 4'(diff[i]);
        end
    end
`else
    assign cnt_inc = 4'd1;
`endif

    // Saturating sum; any carry into the extension bits pins the counter at all-ones.
    assign cnt_sum = {4'b0000, err_count} + {{ERR_W{1'b0}}, cnt_inc};
    assign cnt_sat = (cnt_sum[ERR_W+3:ERR_W] != 4'd0) ? '1 : cnt_sum[ERR_W-1:0];

    // Next-state and datapath decisions; everything advances only on accepted bytes.
    always_comb begin
        state_next  = state;
        b0_lsb_next = b0_lsb;
        exp_next    = exp_q;
        good_next   = good_cnt;
        win_next    = win_cnt;
        errb_next   = errb_cnt;
        errb_base   = errb_cnt;
        win_wrap    = 1'b0;
        err_next    = 1'b0;
        lost_next   = 1'b0;
        cnt_inc_en  = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = SEED_A;
                SEED_A: begin
                    if (rx_valid) begin
                        b0_lsb_next = rx_data[0];
                        state_next  = SEED_B;
                    end
                end
                SEED_B: begin
                    if (rx_valid) begin
                        if (seed != 9'd0) begin
                            exp_next   = seed;
                            good_next  = 8'd0;
                            state_next = VERIFY;
                        end else begin
                            b0_lsb_next = rx_data[0];
                        end
                    end
                end
                VERIFY: begin
                    if (rx_valid) begin
                        if (!mismatch) begin
                            exp_next  = exp_adv;
                            good_next = good_cnt + 8'd1;
                            if (good_cnt + 8'd1 == LOCK_TGT) begin
                                win_next   = 16'd0;
                                errb_next  = 16'd0;
                                state_next = LOCKED;
                            end
                        end else begin
                            b0_lsb_next = rx_data[0];
                            state_next  = SEED_B;
                        end
                    end
                end
                LOCKED: begin
                    if (rx_valid) begin
                        exp_next  = exp_adv;
                        win_wrap  = (win_cnt == WIN_LAST);
                        win_next  = win_wrap ? 16'd0 : win_cnt + 16'd1;
                        errb_base = win_wrap ? 16'd0 : errb_cnt;
                        errb_next = errb_base;
                        if (mismatch) begin
                            err_next   = 1'b1;
                            cnt_inc_en = 1'b1;
                            errb_next  = errb_base + 16'd1;
                            if (errb_base + 16'd1 == THRESH) begin
                                lost_next  = 1'b1;
                                state_next = SEED_A;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        locked_next = (state_next == LOCKED);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Predictor, seed bit and run/window counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b0_lsb   <= 1'b0;
            exp_q    <= 9'd0;
            good_cnt <= 8'd0;
            win_cnt  <= 16'd0;
            errb_cnt <= 16'd0;
        end else begin
            b0_lsb   <= b0_lsb_next;
            exp_q    <= exp_next;
            good_cnt <= good_next;
            win_cnt  <= win_next;
            errb_cnt <= errb_next;
        end
    end

    // Registered outputs; clear takes priority over a same-cycle error increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked    <= 1'b0;
            err       <= 1'b0;
            lock_lost <= 1'b0;
            err_count <= '0;
        end else begin
            locked    <= locked_next;
            err       <= err_next;
            lock_lost <= lost_next;
            if (clear) begin
                err_count <= '0;
            end else if (cnt_inc_en) begin
                err_count <= cnt_sat;
            end
        end
    end

endmodule

// File: tb/tb_slink_prbs9_checker.sv
// tb_slink_prbs9_checker: scoreboard bench for slink_prbs9_checker.
// The reference stream comes from a bit-serial PRBS9 LFSR (x^9 + x^5 + 1) that is
// stepped eight times per byte. Expected outputs are queued as bytes are driven and
// are popped on the falling edge after the DUT samples each byte.
module tb_slink_prbs9_checker;

    localparam int ERR_W   = 4;
    localparam int CNT_MAX = (1 << ERR_W) - 1;

    typedef struct {
        logic e_err;
        logic e_lost;
        logic e_locked;
        int   e_cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             clear;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             locked;
    logic             err;
    logic             lock_lost;
    logic [ERR_W-1:0] err_count;

    exp_t       exp_q[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         exp_cnt    = 0;
    logic [8:0] gs;
    logic       took_byte  = 1'b0;

    always #5 clk = ~clk;

    slink_prbs9_checker #(
        .LOCK_CNT  (4),
        .WINDOW    (64),
        .ERR_THRESH(8),
        .ERR_W     (ERR_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .clear    (clear),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .locked   (locked),
        .err      (err),
        .lock_lost(lock_lost),
        .err_count(err_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Serial LFSR: shift left, feedback tap from bits 8 and 4 enters at bit 0.
    function automatic logic [8:0] stepByte(input logic [8:0] s);
        logic [8:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = {r[7:0], r[8] ^ r[4]};
        end
        return r;
    endfunction

    function automatic int bitInc(input logic [7:0] m);
        int n;
        n = 0;
`ifdef SLINK_PRBS9_CHK_BITCNT_EN
        for (int i = 0; i < 8; i++) begin
            if (m[i]) n++;
        end
`else
        n = 1;
`endif
        return n;
    endfunction

    // Drive one byte for one cycle and queue what the outputs must show afterwards.
    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] mask, input logic e_err,
                                 input logic e_lost, input logic e_locked, input logic clr);
        exp_t x;
        if (clr) begin
            exp_cnt = 0;
        end else if (e_err) begin
            exp_cnt = exp_cnt + bitInc(mask);
            if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
        end
        x.e_err    = e_err;
        x.e_lost   = e_lost;
        x.e_locked = e_locked;
        x.e_cnt    = exp_cnt;
        exp_q.push_back(x);
        rx_data  = d;
        rx_valid = 1'b1;
        clear    = clr;
        @(negedge clk);
        rx_valid = 1'b0;
        clear    = 1'b0;
    endtask

    // Next byte of the reference stream, optionally corrupted by mask.
    task automatic sendNext(input logic [7:0] mask, input logic e_err, input logic e_lost,
                            input logic e_locked, input logic clr);
        gs = stepByte(gs);
        applyStimulus(gs[7:0] ^ mask, mask, e_err, e_lost, e_locked, clr);
    endtask

    // Note which cycles actually presented a byte to the DUT.
    always @(posedge clk) took_byte <= rx_valid;

    // Compare the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (took_byte) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL scoreboard_underflow: got output with empty queue, want queued entry");
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                checkOutput("err", 32'(err), 32'(x.e_err));
                checkOutput("lock_lost", 32'(lock_lost), 32'(x.e_lost));
                checkOutput("locked", 32'(locked), 32'(x.e_locked));
                checkOutput("err_count", 32'(err_count), 32'(x.e_cnt));
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_lock_lost", 32'(lock_lost), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        $display("[TB] clean lock");
        gs = 9'h107;
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(gs[7:0], 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendNext(8'h00, 1'b0, 1'b0, (i == 3), 1'b0);
        for (int i = 0; i < 3; i++) sendNext(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] error injection");
        sendNext(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) sendNext(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        sendNext(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) sendNext(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] loss of lock");
        for (int i = 0; i < 6; i++) sendNext(8'h01, 1'b1, (i == 5), (i != 5), 1'b0);
        for (int i = 0; i < 6; i++) sendNext(8'h00, 1'b0, 1'b0, (i == 5), 1'b0);

        $display("[TB] window wrap and saturation");
        for (int i = 1; i <= 67; i++) begin
            if ((i <= 13 && (i % 2) == 1) || i == 64 || i == 65 || i == 67) begin
                sendNext(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
            end else begin
                sendNext(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end

        $display("[TB] clear against error");
        sendNext(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
        sendNext(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("[TB] enable low while locked");
        enable = 1'b0;
        sendNext(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("en_off_locked", 32'(locked), 32'd0);
        checkOutput("en_off_err_count", 32'(err_count), 32'(exp_cnt));

        $display("[TB] zero seed and verify mismatch");
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) sendNext(8'h00, 1'b0, 1'b0, (i == 5), 1'b0);
        sendNext(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] async reset while locked");
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_locked", 32'(locked), 32'd0);
        checkOutput("arst_err_count", 32'(err_count), 32'd0);
        checkOutput("arst_err", 32'(err), 32'd0);
        checkOutput("arst_lock_lost", 32'(lock_lost), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_locked", 32'(locked), 32'd0);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/slink_prbs9_checker.md
# slink_prbs9_checker

Receive-side PRBS9 checker for S-Link link bring-up and BER test. Consumes one received byte per `rx_valid` from the deserialised lane, self-seeds its 9-bit predictor from the incoming stream, and declares lock after a run of correct bytes. While locked it flags and counts bit/byte errors. It also drops lock when the error density exceeds a threshold. It is the consumer of the byte stream the TX PRBS9 generator produces.

## Interface
- `LOCK_CNT`, 4: consecutive correct bytes in VERIFY required to lock (1..255).
- `WINDOW`, 64: byte window for loss-of-lock evaluation (2..65535).
- `ERR_THRESH`, 8: errored bytes within one window that force loss of lock (1..WINDOW).
- `ERR_W`, 16: width of `err_count`.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous reset, active low.
- `enable`  in  1  checker enable; low forces IDLE.
- `clear`  in  1  synchronous clear of `err_count`.
- `rx_valid`  in  1  `rx_data` is a new byte this cycle.
- `rx_data`  in  8  received byte.
- `locked`  out  1  checker is in LOCKED.
- `err`  out  1  one-cycle pulse: last accepted byte mismatched while locked.
- `lock_lost`  out  1  one-cycle pulse: LOCKED→SEED_A due to error threshold.
- `err_count`  out  ERR_W  saturating error counter.

## Operation
- Sequence definition: 9-bit state p, advanced 8 bits per byte by f(p). n8=p0, n7=p8^p4, n6=p7^p3, n5=p6^p2, n4=p5^p1, n3=p4^p0, n2=p3^p8^p4, n1=p2^p7^p3, n0=p1^p6^p2. The byte for state p is p[7:0].
- Seeding: from consecutive bytes b0, b1, the state of b1 is {b0[0], b1}.
- All state changes occur only on cycles with `rx_valid`=1, except reset, `enable`=0 and `clear`.
- IDLE: `locked`=0. `enable`=1 → SEED_A.
- SEED_A: a valid byte is stored as b0 → SEED_B.
- SEED_B: on a valid byte d, seed={b0[0],d}. If seed≠0, exp<=seed, good_cnt<=0, → VERIFY. If seed=0, b0<=d and stay in SEED_B (the all-zero lock-up state is never accepted).
- VERIFY: on a valid byte d, compute e=f(exp). If d==e[7:0], exp<=e and good_cnt++. When good_cnt reaches LOCK_CNT → LOCKED with win_cnt=errb_cnt=0. On a mismatch, b0<=d → SEED_B. No `err` and no counting in VERIFY.
- LOCKED: on every valid byte, exp<=f(exp) regardless of mismatch (free-running predictor). Mismatch → `err` pulse, errb_cnt++, and `err_count` increment. win_cnt counts valid bytes 0..WINDOW-1.
  - If errb_cnt reaches ERR_THRESH within the window → `lock_lost` pulse, → SEED_A.
  - At win_cnt wrap, win_cnt and errb_cnt reset to 0. An error on the wrap byte counts in the new window as 1.
- `err_count` saturates at all-ones and never wraps. It is retained across loss of lock and `enable` toggles. `clear` zeroes it, and clear wins over a simultaneous increment.
- `enable`=0 in any state → IDLE next cycle; a simultaneous `err`/`lock_lost` is suppressed.

## Timing
- Reset values: state IDLE, `locked`=0, `err`=0, `lock_lost`=0, `err_count`=0, internal counters and exp=0.
- All outputs are registered.
- `err`, `lock_lost` and the `err_count` update appear the cycle after the byte is sampled.
- `locked` rises the cycle after the LOCK_CNT-th correct VERIFY byte. It falls together with the `lock_lost` pulse, or the cycle after `enable` falls.
- Minimum lock latency from first valid byte: 2+LOCK_CNT valid bytes, plus 1 cycle.
- `rx_valid` gaps of any length are tolerated; no timeout.
- `reset_n` assertion mid-operation clears everything asynchronously. Deassertion is synchronised externally.

## Configuration
- `SLINK_PRBS9_CHK_BITCNT_EN` defined: `err_count` increments by popcount(d ^ e[7:0]) (1..8) per errored byte, saturating.
- `SLINK_PRBS9_CHK_BITCNT_EN` undefined: `err_count` increments by 1 per errored byte.
- Lock and loss-of-lock logic are identical in both builds.

## Test plan
- Clean lock: enable, feed 0xFF, 0x07, 0xBE and the continuing sequence (LOCK_CNT=4) → `locked`=1 the cycle after byte 6; `err` never pulses; `err_count`=0.
- Error injection while locked: replace one expected byte with its value ^0x01 → one `err` pulse, `err_count`=1, predictor stays aligned. Then ^0x07 → `err_count`=4 with macro, 2 without.
- Loss of lock: 8 errored bytes within 64 → `lock_lost` pulse on the 8th, `locked`=0. Resume the clean sequence → relock after 6 bytes.
- Zero/garbage seed: feed 0x00 bytes continuously → never leaves SEED_B, `locked`=0, `err`=0. A VERIFY mismatch → re-seed without any `err`.
- Saturation and clear: ERR_W=4, ERR_THRESH=WINDOW=64, 20 single-bit errors → `err_count`=15. Assert `clear` on the same cycle as an error → `err_count`=0.
- Reset/enable mid-lock: assert `reset_n`=0 while locked → all outputs 0 immediately. `enable`=0 while locked → `locked`=0 next cycle, `err_count` retained.
